// File: rtl/dns_pkg.sv
// dns_pkg: DNS wire constants, header flag bit positions, builder states and captured field set
package dns_pkg;
    localparam int DNS_HDR_BYTES = 12;
    localparam logic [15:0] DNS_TYPE_A = 16'h0001;
    localparam logic [15:0] DNS_PTR_QNAME = 16'hC00C;
    localparam logic [15:0] DNS_A_RDLEN = 16'h0004;
    localparam int FLAG_QR = 15;
    localparam int FLAG_OPCODE_LSB = 11;
    localparam int FLAG_AA = 10;
    localparam int FLAG_TC = 9;
    localparam int FLAG_RD = 8;
    localparam int FLAG_RA = 7;
    localparam int FLAG_Z_LSB = 4;
    localparam int FLAG_RCODE_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef DNS_BUILDER_TCP_PREFIX_EN
        S_PREFIX,
`endif
        S_HDR,
        S_QNAME,
        S_QTAIL,
        S_ANS
    } state_e;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] flags;
        logic [15:0] qtype;
        logic [15:0] qclass;
        logic        ans_en;
        logic [31:0] ttl;
        logic [31:0] addr;
    } fields_t;
endpackage

// File: rtl/dns_name_len.sv
// dns_name_len: priority encoder giving encoded QNAME length (first 0x00 index + 1) and truncation flag
module dns_name_len #(
    parameter int NAME_BYTES = 32,
    parameter int LW = $clog2(NAME_BYTES + 2)
) (
    input  logic [8*NAME_BYTES-1:0] name_i,
    output logic [LW-1:0]           len_o,
    output logic                    trunc_o
);
    always_comb begin
        len_o = LW'(NAME_BYTES + 1);
        trunc_o = 1'b1;
        for (int i = NAME_BYTES - 1; i >= 0; i--) begin
            if (name_i[8*(NAME_BYTES-1-i) +: 8] == 8'h00) begin
                len_o = LW'(i + 1);
                trunc_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/dns_builder.sv
// dns_builder: serializes header, one question and an optional A answer into a byte stream.
// DNS_BUILDER_TCP_PREFIX_EN prepends a 2-byte big-endian message length (TCP framing).
module dns_builder #(
    parameter int NAME_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [15:0]             hdr_id,
    input  logic [15:0]             hdr_flags,
    input  logic [8*NAME_BYTES-1:0] qry_name,
    input  logic [15:0]             qry_type,
    input  logic [15:0]             qry_class,
    input  logic                    ans_en,
    input  logic [31:0]             ans_ttl,
    input  logic [31:0]             ans_addr,
    output logic [7:0]              m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    name_trunc
);
    import dns_pkg::*;

    localparam int LW = $clog2(NAME_BYTES + 2);
    localparam int CW = LW > 4 ? LW : 4;
`ifdef DNS_BUILDER_TCP_PREFIX_EN
    localparam state_e S_FIRST = S_PREFIX;
`else
    localparam state_e S_FIRST = S_HDR;
`endif

    state_e state_q, state_d, nxt;
    logic [CW-1:0] cnt_q, cnt_d, last;
    fields_t f_q, f_d, in_f;
    logic [8*NAME_BYTES-1:0] name_q, name_d;
    logic [LW-1:0] len_q, len_d, len_w;
    logic trunc_w, trunc_q;
    logic [7:0] m_data_q, m_data_d;
    logic m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic acc, fire, step;
    logic [127:0] vec;
    logic [15:0] total;

    dns_name_len #(.NAME_BYTES(NAME_BYTES), .LW(LW)) u_name_len (
        .name_i (qry_name),
        .len_o  (len_w),
        .trunc_o(trunc_w)
    );

    assign req_ready = state_q == S_IDLE;
    assign m_data = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last = m_last_q;
    assign name_trunc = trunc_q;

    // state_q/cnt_q name the byte currently held in m_data_q; the next byte is precomputed on each step
    always_comb begin
        acc = req_valid && req_ready;
        fire = m_valid_q && m_ready;
        in_f = '{id: hdr_id, flags: hdr_flags, qtype: qry_type, qclass: qry_class,
                 ans_en: ans_en, ttl: ans_ttl, addr: ans_addr};
        f_d = acc ? in_f : f_q;
        name_d = acc ? qry_name : name_q;
        len_d = acc ? len_w : len_q;
        last = state_q == S_HDR   ? CW'(DNS_HDR_BYTES - 1) :
               state_q == S_QNAME ? CW'(len_q) - CW'(1) :
               state_q == S_QTAIL ? CW'(3) :
               state_q == S_ANS   ? CW'(15) : CW'(1);
        nxt = state_q == S_HDR                ? S_QNAME :
              state_q == S_QNAME              ? S_QTAIL :
              state_q == S_QTAIL && f_q.ans_en ? S_ANS :
              state_q == S_QTAIL || state_q == S_ANS ? S_IDLE : S_HDR;
        step = fire && cnt_q == last;
        state_d = acc ? S_FIRST : step ? nxt : state_q;
        cnt_d = acc || step ? '0 : fire ? cnt_q + CW'(1) : cnt_q;
        total = 16'(16 + int'(len_d) + (f_d.ans_en ? 16 : 0));
        vec = state_d == S_HDR   ? {f_d.id, f_d.flags, 16'd1, 15'd0, f_d.ans_en, 64'd0} :
              state_d == S_QTAIL ? {f_d.qtype, f_d.qclass, 96'd0} :
              state_d == S_ANS   ? {DNS_PTR_QNAME, DNS_TYPE_A, f_d.qclass, f_d.ttl, DNS_A_RDLEN, f_d.addr} :
`ifdef DNS_BUILDER_TCP_PREFIX_EN
              state_d == S_PREFIX ? {total, 112'd0} :
`endif
              128'd0;
        m_valid_d = acc || fire ? state_d != S_IDLE : m_valid_q;
        m_data_d = !(acc || fire) ? m_data_q :
                   state_d == S_QNAME ? 8'((name_d << {cnt_d, 3'b000}) >> (8*NAME_BYTES - 8)) :
                   8'(vec >> {4'd15 - cnt_d[3:0], 3'b000});
        m_last_d = acc || fire ? (state_d == S_ANS && cnt_d == CW'(15)) ||
                                 (state_d == S_QTAIL && cnt_d == CW'(3) && !f_d.ans_en) : m_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            f_q <= '0;
            name_q <= '0;
            len_q <= '0;
            trunc_q <= 1'b0;
            m_data_q <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            f_q <= f_d;
            name_q <= name_d;
            len_q <= len_d;
            trunc_q <= acc && trunc_w;
            m_data_q <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q <= m_last_d;
        end
    end

    logic unused_total;
    assign unused_total = ^total;
endmodule

// File: tb/tb_dns_builder.sv
// tb_dns_builder: directed vectors for the DNS builder with hand-computed wire bytes
module tb_dns_builder;
    localparam logic [255:0] NAME_AIO = {48'h016102696F00, {26{8'hAA}}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [15:0] hdr_id = '0, hdr_flags = '0, qry_type = '0, qry_class = '0;
    logic [255:0] qry_name = '0;
    logic ans_en = 1'b0;
    logic [31:0] ans_ttl = '0, ans_addr = '0;
    logic [7:0] m_data;
    logic m_valid, m_last, name_trunc;
    logic m_ready = 1'b0;

    dns_builder #(.NAME_BYTES(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .hdr_id(hdr_id), .hdr_flags(hdr_flags), .qry_name(qry_name), .qry_type(qry_type),
        .qry_class(qry_class), .ans_en(ans_en), .ans_ttl(ans_ttl), .ans_addr(ans_addr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .name_trunc(name_trunc)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, trunc_seen = 0;
    always @(negedge clk) if (name_trunc) trunc_seen++;

    logic [7:0] rx_q[$], exp_q[$];
    int last_idx, last_cnt, cyc;
    bit unstable, ready_bad, timeout;

    task automatic add_prefix();
`ifdef DNS_BUILDER_TCP_PREFIX_EN
        int n = exp_q.size();
        exp_q.push_front(8'(n));
        exp_q.push_front(8'(n >> 8));
`endif
    endtask

    task automatic exp_case1();
        exp_q = {8'h12, 8'h34, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h61, 8'h02, 8'h69, 8'h6F, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        add_prefix();
    endtask

    task automatic exp_case2();
        exp_q = {8'h12, 8'h34, 8'h81, 8'h80, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h61, 8'h02, 8'h69, 8'h6F, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01,
                 8'hC0, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h3C,
                 8'h00, 8'h04, 8'h0A, 8'h00, 8'h00, 8'h01};
        add_prefix();
    endtask

    // presents one field set, then scrambles the inputs so only captured values can reach the stream
    task automatic drive(input logic [15:0] id, input logic [15:0] flags, input logic [255:0] name,
                         input logic [15:0] qt, input logic [15:0] qc, input logic ans,
                         input logic [31:0] ttl, input logic [31:0] addr);
        int n = 0;
        hdr_id = id; hdr_flags = flags; qry_name = name; qry_type = qt; qry_class = qc;
        ans_en = ans; ans_ttl = ttl; ans_addr = addr; req_valid = 1'b1;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        hdr_id = 16'($urandom); hdr_flags = 16'($urandom); qry_name = {8{32'($urandom)}};
        qry_type = 16'($urandom); qry_class = 16'($urandom); ans_en = 1'($urandom);
        ans_ttl = $urandom; ans_addr = $urandom;
    endtask

    // records handshaken bytes and protocol observations; stops on m_last or after stop_after bytes
    task automatic capture(input bit stall, input int stop_after);
        bit hold = 0, done = 0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        rx_q.delete(); last_idx = -1; last_cnt = 0; cyc = 0;
        unstable = 0; ready_bad = 0; timeout = 0;
        forever begin
            if (cyc > 2000) begin timeout = 1; break; end
            m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold && (!m_valid || m_data !== pd || m_last !== pl)) unstable = 1;
            if (req_ready) ready_bad = 1;
            hold = m_valid && !m_ready; pd = m_data; pl = m_last;
            if (m_valid && m_ready) begin
                rx_q.push_back(m_data);
                if (m_last) begin last_cnt++; last_idx = rx_q.size(); done = 1; end
                if (rx_q.size() == stop_after) done = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data got %h want 00", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got %b want 0", m_last); end
        checks++; if (name_trunc !== 1'b0) begin errors++; $display("FAIL rst_name_trunc got %b want 0", name_trunc); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (m_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL idle_m_ready got valid=%b ready=%b want 0 1", m_valid, req_ready); end
        m_ready = 1'b0;
    endtask

    task automatic test_query();
        int t0 = trunc_seen;
        exp_case1();
        drive(16'h1234, 16'h0100, NAME_AIO, 16'h0001, 16'h0001, 1'b0, 32'h0, 32'h0);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL q_first_valid got %b want 1", m_valid); end
        capture(0, 0);
        checks++; if (timeout || rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL q_len got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL q_byte%0d got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (last_cnt != 1 || last_idx != exp_q.size()) begin
            errors++; $display("FAIL q_last got idx %0d count %0d want idx %0d count 1", last_idx, last_cnt, exp_q.size()); end
        checks++; if (cyc != exp_q.size()) begin errors++; $display("FAIL q_cycles got %0d want %0d", cyc, exp_q.size()); end
        checks++; if (ready_bad) begin errors++; $display("FAIL q_req_ready got high while streaming want low"); end
        checks++; if (trunc_seen != t0) begin errors++; $display("FAIL q_trunc got %0d pulses want 0", trunc_seen - t0); end
    endtask

    task automatic test_answer_back_to_back();
        exp_case2();
        checks++; if (req_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got ready=%b valid=%b want 1 0", req_ready, m_valid); end
        drive(16'h1234, 16'h8180, NAME_AIO, 16'h0001, 16'h0001, 1'b1, 32'h0000003C, 32'h0A000001);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL a_first_valid got %b want 1", m_valid); end
        capture(0, 0);
        checks++; if (timeout || rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL a_len got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL a_byte%0d got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (last_cnt != 1 || last_idx != exp_q.size()) begin
            errors++; $display("FAIL a_last got idx %0d count %0d want idx %0d count 1", last_idx, last_cnt, exp_q.size()); end
        checks++; if (cyc != exp_q.size()) begin errors++; $display("FAIL a_cycles got %0d want %0d", cyc, exp_q.size()); end
    endtask

    task automatic test_stalls();
        exp_case2();
        repeat (4) begin m_ready = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
        m_ready = 1'b0;
        drive(16'h1234, 16'h8180, NAME_AIO, 16'h0001, 16'h0001, 1'b1, 32'h0000003C, 32'h0A000001);
        capture(1, 0);
        checks++; if (timeout || rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL s_len got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL s_byte%0d got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (unstable) begin errors++; $display("FAIL s_stable got output change during stall want held"); end
        checks++; if (ready_bad) begin errors++; $display("FAIL s_req_ready got high while streaming want low"); end
        checks++; if (last_cnt != 1 || last_idx != exp_q.size()) begin
            errors++; $display("FAIL s_last got idx %0d count %0d want idx %0d", last_idx, last_cnt, exp_q.size()); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL s_idle_after got %b want 1", req_ready); end
    endtask

    task automatic test_trunc();
        logic [255:0] nm;
        int t0 = trunc_seen;
        for (int i = 0; i < 32; i++) nm[8*(31-i) +: 8] = 8'(i + 1);
        exp_q = {8'hBE, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 32; i++) exp_q.push_back(8'(i + 1));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h1C); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        add_prefix();
        drive(16'hBEEF, 16'h0100, nm, 16'h001C, 16'h0001, 1'b0, 32'h0, 32'h0);
        checks++; if (name_trunc !== 1'b1) begin errors++; $display("FAIL t_pulse got %b want 1", name_trunc); end
        capture(0, 0);
        checks++; if (trunc_seen - t0 != 1) begin errors++; $display("FAIL t_pulse_count got %0d want 1", trunc_seen - t0); end
        checks++; if (timeout || rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL t_len got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL t_byte%0d got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (last_idx != exp_q.size()) begin errors++; $display("FAIL t_last got %0d want %0d", last_idx, exp_q.size()); end
    endtask

    task automatic test_abort_reset();
        exp_case1();
        drive(16'h1234, 16'h0100, NAME_AIO, 16'h0001, 16'h0001, 1'b0, 32'h0, 32'h0);
        capture(0, 9);
        checks++; if (m_valid !== 1'b1 || m_data !== exp_q[9]) begin
            errors++; $display("FAIL r_byte10 got valid=%b data=%h want 1 %h", m_valid, m_data, exp_q[9]); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || req_ready !== 1'b1 || m_last !== 1'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL r_abort got valid=%b ready=%b last=%b data=%h want 0 1 0 00",
                               m_valid, req_ready, m_last, m_data); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(16'h1234, 16'h0100, NAME_AIO, 16'h0001, 16'h0001, 1'b0, 32'h0, 32'h0);
        capture(0, 0);
        checks++; if (timeout || rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL r_len got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL r_byte%0d got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (last_cnt != 1 || last_idx != exp_q.size()) begin
            errors++; $display("FAIL r_last got idx %0d want %0d", last_idx, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_query();
        test_answer_back_to_back();
        test_stalls();
        test_trunc();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dns_builder.md
# dns_builder

DNS message serializer: the transmit-side counterpart of the DNS analyzer. Accepts one set of message fields per handshake (header, single question, optional single A-record answer) and emits the wire-format DNS message as a big-endian byte stream with valid/ready flow control. Sits between the DNS responder/query logic and the UDP payload path of the Ethernet stack.

## Interface
- NAME_BYTES, 32: capacity of `qry_name` in bytes. Minimum 2.
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  field set valid
- req_ready  out  1  builder idle, fields accepted on `req_valid && req_ready`
- hdr_id  in  16  transaction ID
- hdr_flags  in  16  {qr, opcode[3:0], aa, tc, rd, ra, z[2:0], rcode[3:0]}
- qry_name  in  8*NAME_BYTES  label-encoded name; byte 0 at MSBs; zero-terminated
- qry_type  in  16  question QTYPE
- qry_class  in  16  question QCLASS
- ans_en  in  1  append one A answer
- ans_ttl  in  32  answer TTL
- ans_addr  in  32  IPv4 address
- m_data  out  8  stream byte
- m_valid  out  1  `m_data` valid
- m_ready  in  1  downstream accepts byte
- m_last  out  1  final byte of message
- name_trunc  out  1  one-cycle pulse: no terminator found in `qry_name`

## Operation
- Fields captured into registers at acceptance; inputs ignored afterwards.
- Name length L = index of first 0x00 byte + 1; if none in NAME_BYTES, L = NAME_BYTES + 1, a 0x00 byte is appended and `name_trunc` pulses on the acceptance cycle+1.
- Emitted order, big-endian:
  - Header, 12 B: id, flags, QDCOUNT=1, ANCOUNT=ans_en, NSCOUNT=0, ARCOUNT=0.
  - QNAME, L B; QTYPE, QCLASS (4 B).
  - If ans_en, 16 B: C0 0C, TYPE=0x0001, CLASS=captured qry_class, TTL, RDLENGTH=0x0004, addr.
- Total N = 16 + L (+16 if ans_en).
- FSM: IDLE -> (accept) HDR -> QNAME -> QTAIL -> ANS (ans_en) -> IDLE. Each state owns a byte counter; advance on `m_valid && m_ready`; exit after its last byte. IDLE reached after handshake of the `m_last` byte.
- `m_last` high exactly with byte N (or N+2 with prefix).

## Timing
- Reset: state IDLE, `req_ready`=1, `m_valid`=0, `m_data`=0x00, `m_last`=0, `name_trunc`=0, counters 0.
- `req_ready` = (state == IDLE); never high while streaming. Back-to-back: new request accepted the cycle after the last byte's handshake.
- First byte valid the cycle after acceptance; one byte per cycle under continuous `m_ready`; throughput N cycles per message + 1 idle cycle.
- `m_data`/`m_last` registered, held stable while `m_valid && !m_ready`; `m_valid` never drops before handshake.
- `rst_n` assertion mid-message: stream aborts immediately, outputs to reset values; no `m_last` emitted.
- `m_ready` asserted with `m_valid` low: no effect.

## Configuration
- `DNS_BUILDER_TCP_PREFIX_EN` defined: each message preceded by 2-byte big-endian length N (DNS-over-TCP framing); extra PREFIX state between IDLE and HDR; first byte = N[15:8].
- Undefined: UDP framing, no prefix, PREFIX state absent.

## Structure
- `dns_pkg`: state enum, DNS_HDR_BYTES=12, DNS_TYPE_A=16'h0001, DNS_PTR_QNAME=16'hC00C, DNS_A_RDLEN=16'h0004, flag-field bit positions (shared with analyzer).
- Sub-module `dns_name_len`: combinational priority encoder over `qry_name` returning L and truncation flag.

## Test plan
- Query, name 01 61 02 69 6F 00 ("a.io"), id 0x1234, flags 0x0100, type 1, class 1, ans_en=0 -> 22 bytes: 12 34 01 00 00 01 00 00 00 00 00 00 01 61 02 69 6F 00 00 01 00 01, `m_last` on byte 22.
- Same with ans_en=1, flags 0x8180, ttl 0x3C, addr 0x0A000001 -> 38 bytes, ANCOUNT=00 01, tail C0 0C 00 01 00 01 00 00 00 3C 00 04 0A 00 00 01.
- Random `m_ready` stalls on case 2 -> byte sequence identical, data stable during stalls, `req_ready` low until final handshake.
- All 32 name bytes nonzero -> `name_trunc` pulse, L=33, 0x00 inserted, 49 bytes total (ans_en=0).
- `rst_n` low at byte 10 -> `m_valid`=0 at once, `req_ready`=1; next request emits a complete correct message.
- With `DNS_BUILDER_TCP_PREFIX_EN`, case 2 -> 40 bytes starting 00 26.
